cpu_registers: RTL
==================

CPU_REGISTERS -- requirements
Module: cpu_registers

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL provide: rd1_sel input 3 (8-bit read port 1 select; 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A); rd1_data output 8 (port 1 value, feeds ALU operand A).
REQ-003 SHALL provide: rd2_sel input 3 (same encoding); rd2_data output 8 (port 2 value, feeds ALU operand B).
REQ-004 SHALL provide: wr_en input 1 (8-bit write strobe); wr_sel input 3 (same encoding); wr_data input 8 (write value, normally ALU result).
REQ-005 SHALL provide: flag_wr_en input 1 (flag update strobe); flag_wr_data input 4 (flags in CHNZ order, bit0 C, bit1 H, bit2 N, bit3 Z; from ALU flag output); flags output 4 (current CHNZ, feeds ALU flag input).
REQ-006 SHALL provide: pair_sel input 2 (0 BC, 1 DE, 2 HL, 3 SP); pair_op input 2 (0 none, 1 write, 2 inc, 3 dec); pair_wr_data input 16 (value for pair write); pair_data output 16 (current value of selected pair).
REQ-007 SHALL provide: pc_op input 2 (0 hold, 1 write, 2 inc); pc_wr_data input 16; pc output 16; sp output 16.

Function
- REQ-008 SHALL make all read outputs purely combinational from current register state, with no write-to-read bypass; a value written at edge N appears after edge N.
- REQ-009 SHALL, on wr_en, load wr_data into the register selected by wr_sel at the next edge.
- REQ-010 SHALL store F bits 7:4 as Z,N,H,C; F bits 3:0 SHALL read as 0 on every port and SHALL never become nonzero.
- REQ-011 SHALL, on wr_en with wr_sel=6, load wr_data[7:4] into F[7:4] and discard wr_data[3:0].
- REQ-012 SHALL, on flag_wr_en, load flag_wr_data into F[7:4] with the mapping Z=bit3, N=bit2, H=bit1, C=bit0.
- REQ-013 SHALL give flag_wr_en priority over wr_en with wr_sel=6 in the same cycle.
- REQ-014 SHALL, for pair_op=write, load pair_wr_data[15:8] into the high register and [7:0] into the low register (B:C, D:E, H:L) or all 16 bits into SP.
- REQ-015 SHALL, for pair_op inc or dec, compute the selected pair +1 or -1 modulo 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF) and write it back; flags SHALL be unaffected.
- REQ-016 SHALL give a pair operation priority over wr_en on any byte of the selected pair in the same cycle; a wr_en to a register outside the pair SHALL still complete.
- REQ-017 SHALL treat pair_op=write/inc/dec on pair 3 as acting on SP only; F and A SHALL never be touched by pair ops.
- REQ-018 SHALL, for pc_op write, load pc_wr_data; for inc, load pc+1 modulo 2^16; for hold, or for reserved code 3, keep pc unchanged.
- REQ-019 SHALL allow wr_en, flag_wr_en, pair_op and pc_op in one cycle with all non-conflicting updates taking effect at the same edge.

Reset
- REQ-020 SHALL, while reset is high at an edge, set A, F, B, C, D, E, H, L, SP and PC to 0x00/0x0000, overriding all write, pair and pc operations that cycle.
- REQ-021 SHALL therefore drive every output to 0 in the cycle after a reset edge: rd1_data, rd2_data, flags, pair_data, pc, sp.
- REQ-022 SHALL discard a pair inc/dec or PC operation whose edge coincides with reset.

Structure
- REQ-023 SHALL place the register-select encoding, pair encoding, pair_op and pc_op encodings, and CHNZ flag index constants in shared package cpu_pkg, also used by the ALU decode.
- REQ-024 SHALL instantiate a single 16-bit incrementer/decrementer sub-module, inc_dec_16, shared by pair inc/dec; PC increment SHALL use a separate adder.

Verification
- REQ-025 Bench SHALL check: reset, then wr_en sel=7 data 0x3C -> rd1_sel=7 reads 0x3C next cycle and still reads 0x00 in the write cycle.
- REQ-026 Bench SHALL check: wr_en sel=6 data 0xFF -> F reads 0xF0 and flags=0xF; then flag_wr_en 0x9 together with wr_en sel=6 data 0x00 -> F=0x90.
- REQ-027 Bench SHALL check: pair write HL=0xFFFF, then pair inc HL -> H=0x00, L=0x00 and flags unchanged; SP=0x0000 dec -> sp=0xFFFF.
- REQ-028 Bench SHALL check: pair inc BC (BC=0x12FF) together with wr_en sel=1 data 0xAA and wr_en... using sel=7 instead -> BC=0x1300 when targeting C (pair wins); A updates when targeting A.
- REQ-029 Bench SHALL check: pc write 0xFFFF, then pc inc -> pc=0x0000; pc inc asserted with reset -> pc=0x0000.
- REQ-030 Bench SHALL check: all registers loaded nonzero, then reset pulsed with concurrent wr_en, pair inc and pc inc -> all outputs read 0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the register file and ALU decode: register selects,
// register pairs, pair/PC operations and CHNZ flag bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        SEL_B = 3'd0,
        SEL_C = 3'd1,
        SEL_D = 3'd2,
        SEL_E = 3'd3,
        SEL_H = 3'd4,
        SEL_L = 3'd5,
        SEL_F = 3'd6,
        SEL_A = 3'd7
    } reg_sel_e;

    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_SP = 2'd3
    } pair_sel_e;

    typedef enum logic [1:0] {
        PAIR_NONE  = 2'd0,
        PAIR_WRITE = 2'd1,
        PAIR_INC   = 2'd2,
        PAIR_DEC   = 2'd3
    } pair_op_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_WRITE = 2'd1,
        PC_INC   = 2'd2,
        PC_RSVD  = 2'd3
    } pc_op_e;

    // Bit positions within the 4-bit CHNZ flag vector (F[7:4] = Z,N,H,C).
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

endpackage

// File: rtl/cpu_registers_inc_dec.sv
// 16-bit wrap-around incrementer/decrementer shared by the register-pair
// inc/dec operations.
module inc_dec_16 (
    input  logic [15:0] value,
    input  logic        dec,
    output logic [15:0] result
);

    assign result = dec ? (value - 16'd1) : (value + 16'd1);

endmodule

// File: rtl/cpu_registers.sv
// 8-bit CPU register file (A,F,B,C,D,E,H,L) with 16-bit pair access, SP and PC.
// Reads are purely combinational from stored state; all writes land on clk.
module cpu_registers
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rd1_sel,
    output logic [7:0]  rd1_data,
    input  logic [2:0]  rd2_sel,
    output logic [7:0]  rd2_data,
    input  logic        wr_en,
    input  logic [2:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic        flag_wr_en,
    input  logic [3:0]  flag_wr_data,
    output logic [3:0]  flags,
    input  logic [1:0]  pair_sel,
    input  logic [1:0]  pair_op,
    input  logic [15:0] pair_wr_data,
    output logic [15:0] pair_data,
    input  logic [1:0]  pc_op,
    input  logic [15:0] pc_wr_data,
    output logic [15:0] pc,
    output logic [15:0] sp
);

    logic [7:0]  reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
    logic [3:0]  flag_q;
    logic [15:0] sp_q, pc_q;

    reg_sel_e    w_sel;
    pair_sel_e   p_sel;
    pair_op_e    p_op;
    pc_op_e      c_op;

    logic [7:0]  reg_view [8];
    logic [15:0] pair_cur;
    logic [15:0] pair_step;
    logic [15:0] pair_next;
    logic [15:0] pc_plus_one;

    assign w_sel = reg_sel_e'(wr_sel);
    assign p_sel = pair_sel_e'(pair_sel);
    assign p_op  = pair_op_e'(pair_op);
    assign c_op  = pc_op_e'(pc_op);

    // F low nibble is not stored, so it reads as zero on every path.
    always_comb begin
        reg_view[SEL_B] = reg_b;
        reg_view[SEL_C] = reg_c;
        reg_view[SEL_D] = reg_d;
        reg_view[SEL_E] = reg_e;
        reg_view[SEL_H] = reg_h;
        reg_view[SEL_L] = reg_l;
        reg_view[SEL_F] = {flag_q, 4'h0};
        reg_view[SEL_A] = reg_a;
    end

    assign rd1_data = reg_view[rd1_sel];
    assign rd2_data = reg_view[rd2_sel];
    assign flags    = flag_q;
    assign sp       = sp_q;
    assign pc       = pc_q;

    always_comb begin
        pair_cur = sp_q;
        case (p_sel)
            PAIR_BC: pair_cur = {reg_b, reg_c};
            PAIR_DE: pair_cur = {reg_d, reg_e};
            PAIR_HL: pair_cur = {reg_h, reg_l};
            PAIR_SP: pair_cur = sp_q;
            default: pair_cur = sp_q;
        endcase
    end

    assign pair_data = pair_cur;

    inc_dec_16 u_inc_dec (
        .value  (pair_cur),
        .dec    (p_op == PAIR_DEC),
        .result (pair_step)
    );

    assign pair_next   = (p_op == PAIR_WRITE) ? pair_wr_data : pair_step;
    assign pc_plus_one = pc_q + 16'd1;

    // Priority is expressed by assignment order: a later non-blocking write to
    // the same register wins, so flag writes beat F byte writes and pair ops
    // beat byte writes to either half of the selected pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_c  <= '0;
            reg_d  <= '0;
            reg_e  <= '0;
            reg_h  <= '0;
            reg_l  <= '0;
            flag_q <= '0;
            sp_q   <= '0;
            pc_q   <= '0;
        end else begin
            if (wr_en) begin
                case (w_sel)
                    SEL_B:   reg_b  <= wr_data;
                    SEL_C:   reg_c  <= wr_data;
                    SEL_D:   reg_d  <= wr_data;
                    SEL_E:   reg_e  <= wr_data;
                    SEL_H:   reg_h  <= wr_data;
                    SEL_L:   reg_l  <= wr_data;
                    SEL_F:   flag_q <= wr_data[7:4];
                    SEL_A:   reg_a  <= wr_data;
                    default: ;
                endcase
            end

            if (flag_wr_en)
                flag_q <= flag_wr_data;

            if (p_op != PAIR_NONE) begin
                case (p_sel)
                    PAIR_BC: {reg_b, reg_c} <= pair_next;
                    PAIR_DE: {reg_d, reg_e} <= pair_next;
                    PAIR_HL: {reg_h, reg_l} <= pair_next;
                    PAIR_SP: sp_q           <= pair_next;
                    default: ;
                endcase
            end

            case (c_op)
                PC_WRITE: pc_q <= pc_wr_data;
                PC_INC:   pc_q <= pc_plus_one;
                default:  ;
            endcase
        end
    end

endmodule
